// File: rtl/fifo_nw_pkg.sv
// rtl/fifo_nw_pkg.sv - shared helpers for the multi-write FIFO
// Purpose: ceiling-log2 helper used to size pointers and counters, and the
//          "no element" fill value returned when the FIFO has nothing to show.
// Ports:   none (package).
package fifo_nw_pkg;

    // Ceiling log2; clogb2(1) = 0, clogb2(8) = 3, clogb2(9) = 4.
    function automatic int clogb2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Empty-slot / no-data marker is all ones at any entry width.
    localparam logic ELEM_NONE_BIT = 1'b1;

endpackage

// File: rtl/fifo_nw_compact.sv
// rtl/fifo_nw_compact.sv - lane compaction for the multi-write FIFO
// Purpose: turns a sparse per-lane write request into a dense run of slots
//          starting at tail, limited by free space.
// Ports:   w_val/w_data   - per-lane requests and data (lane 0 oldest)
//          free/tail      - free slot count and current write pointer
//          w_acc/n_acc    - accepted lanes and their count
//          slot_we/wdata  - per-memory-slot write enable and data
//          byp_data       - lowest valid lane's data (empty-FIFO bypass)
//          any_val        - at least one lane is requesting
module fifo_nw_compact
    import fifo_nw_pkg::*;
#(
    parameter int NUM_W      = 2,
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = clogb2(FIFO_DEPTH) + 1,
    parameter int AW         = clogb2(FIFO_DEPTH)
) (
    input  logic [NUM_W-1:0]                      w_val,
    input  logic [NUM_W*FIFO_WIDTH-1:0]           w_data,
    input  logic [CNT_WIDTH-1:0]                  free,
    input  logic [AW-1:0]                         tail,
    output logic [NUM_W-1:0]                      w_acc,
    output logic [CNT_WIDTH-1:0]                  n_acc,
    output logic [FIFO_DEPTH-1:0]                 slot_we,
    output logic [FIFO_DEPTH-1:0][FIFO_WIDTH-1:0] slot_wdata,
    output logic [FIFO_WIDTH-1:0]                 byp_data,
    output logic                                  any_val
);

    // prefix[i] = number of valid lanes below lane i, i.e. lane i's offset
    // from tail once the valid lanes are packed together.
    logic [CNT_WIDTH-1:0] prefix [NUM_W];

    always_comb begin
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] acc_cnt;
        cnt     = '0;
        acc_cnt = '0;
        w_acc   = '0;
        for (int i = 0; i < NUM_W; i++) begin
            prefix[i] = cnt;
            if (w_val[i]) begin
                // Only the first 'free' valid lanes fit; the rest are refused.
                if (cnt < free) begin
                    w_acc[i] = 1'b1;
                    acc_cnt  = acc_cnt + 1'b1;
                end
                cnt = cnt + 1'b1;
            end
        end
        n_acc = acc_cnt;
    end

    always_comb begin
        byp_data = {FIFO_WIDTH{ELEM_NONE_BIT}};
        any_val  = |w_val;
        // Walk downward so the lowest valid lane wins.
        for (int i = NUM_W - 1; i >= 0; i--) begin
            if (w_val[i]) begin
                byp_data = w_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // NUM_W never exceeds FIFO_DEPTH, so accepted lanes never alias one slot.
    always_comb begin
        for (int s = 0; s < FIFO_DEPTH; s++) begin
            slot_we[s]    = 1'b0;
            slot_wdata[s] = {FIFO_WIDTH{ELEM_NONE_BIT}};
            for (int i = 0; i < NUM_W; i++) begin
                if (w_acc[i] && ((tail + AW'(prefix[i])) == AW'(s))) begin
                    slot_we[s]    = 1'b1;
                    slot_wdata[s] = w_data[i*FIFO_WIDTH +: FIFO_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/fifo_nw.sv
// rtl/fifo_nw.sv - multi-lane write, single-read first-word fall-through FIFO
// Purpose: accepts up to NUM_W entries per cycle (compacted in lane order),
//          pops one per cycle, and bypasses the lowest valid lane to r_data
//          when empty.
// Ports:   clk, rst_n            - clock, async active-low reset
//          w_val/w_data/w_acc    - per-lane write request/data/accept
//          r_val/r_data          - pop request and head data
//          data_avail            - r_data is valid this cycle
//          size/full/afull       - registered occupancy and flags
module fifo_nw
    import fifo_nw_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_W      = 2,
    parameter int AFULL_LVL  = FIFO_DEPTH - 2,
    parameter int CNT_WIDTH  = clogb2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_W-1:0]              w_val,
    input  logic [NUM_W*FIFO_WIDTH-1:0]   w_data,
    output logic [NUM_W-1:0]              w_acc,
    input  logic                          r_val,
    output logic [FIFO_WIDTH-1:0]         r_data,
    output logic                          data_avail,
    output logic [CNT_WIDTH-1:0]          size,
    output logic                          full,
    output logic                          afull
);

    localparam int AW = clogb2(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  size_q, size_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;

    logic [CNT_WIDTH-1:0]                  free;
    logic [NUM_W-1:0]                      acc_raw;
    logic [CNT_WIDTH-1:0]                  n_acc;
    logic [FIFO_DEPTH-1:0]                 slot_we;
    logic [FIFO_DEPTH-1:0][FIFO_WIDTH-1:0] slot_wdata;
    logic [FIFO_WIDTH-1:0]                 byp_data;
    logic                                  any_val;
    logic                                  empty;
    logic                                  pop;

    // Free space uses registered size only: a same-cycle pop does not make
    // room for writes, which keeps the accept path off the pop logic.
    assign free  = CNT_WIDTH'(FIFO_DEPTH) - size_q;
    assign empty = (size_q == '0);

    fifo_nw_compact #(
        .NUM_W      (NUM_W),
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .AW         (AW)
    ) u_compact (
        .w_val      (w_val),
        .w_data     (w_data),
        .free       (free),
        .tail       (tail_q),
        .w_acc      (acc_raw),
        .n_acc      (n_acc),
        .slot_we    (slot_we),
        .slot_wdata (slot_wdata),
        .byp_data   (byp_data),
        .any_val    (any_val)
    );

    // Accept and availability are held low while reset is asserted so the
    // producer never sees a handshake that the reset is about to discard.
    assign w_acc      = rst_n ? acc_raw : '0;
    assign data_avail = rst_n & (~empty | any_val);
    assign pop        = r_val & data_avail;

    always_comb begin
        r_data = {FIFO_WIDTH{ELEM_NONE_BIT}};
        if (!empty) begin
            r_data = mem_q[head_q];
        end else if (rst_n && any_val) begin
            r_data = byp_data;
        end
    end

    // A bypassed entry is still written at tail (== head when empty) and
    // head steps past it on the pop, so it is consumed without being seen
    // again; the remaining accepted lanes follow it in order.
    always_comb begin
        mem_d = mem_q;
        for (int s = 0; s < FIFO_DEPTH; s++) begin
            if (slot_we[s]) begin
                mem_d[s] = slot_wdata[s];
            end
        end
        tail_d  = tail_q + n_acc[AW-1:0];
        head_d  = head_q + AW'(pop);
        size_d  = size_q + n_acc - CNT_WIDTH'(pop);
        full_d  = (size_d == CNT_WIDTH'(FIFO_DEPTH));
        afull_d = (size_d >= CNT_WIDTH'(AFULL_LVL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < FIFO_DEPTH; s++) begin
                mem_q[s] <= {FIFO_WIDTH{ELEM_NONE_BIT}};
            end
            head_q  <= '0;
            tail_q  <= '0;
            size_q  <= '0;
            full_q  <= 1'b0;
            afull_q <= (AFULL_LVL == 0);
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            size_q  <= size_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

    assign size  = size_q;
    assign full  = full_q;
    assign afull = afull_q;

endmodule

// File: tb/tb_fifo_nw.sv
// tb/tb_fifo_nw.sv - directed and scoreboard bench for fifo_nw (W=8, D=8, 3 lanes)
module tb_fifo_nw;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int NW = 3;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NW-1:0]     w_val;
    logic [NW*W-1:0]   w_data;
    logic [NW-1:0]     w_acc;
    logic              r_val;
    logic [W-1:0]      r_data;
    logic              data_avail;
    logic [CW-1:0]     size;
    logic              full;
    logic              afull;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_nw #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D),
        .NUM_W      (NW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_val      (w_val),
        .w_data     (w_data),
        .w_acc      (w_acc),
        .r_val      (r_val),
        .r_data     (r_data),
        .data_avail (data_avail),
        .size       (size),
        .full       (full),
        .afull      (afull)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NW-1:0] v, input logic [NW*W-1:0] d, input logic r);
        w_val  = v;
        w_data = d;
        r_val  = r;
        #1;
    endtask

    logic [W-1:0]    q [$];
    logic [W-1:0]    drain_exp [7];
    logic [NW-1:0]   m, ea;
    logic [NW*W-1:0] d;
    logic            r, eav, skip;
    logic [W-1:0]    erd;
    int              pushed, msz, free, k;

    initial begin
        drain_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0A, 8'h0B};

        // Reset state, with requests present to show they are masked.
        rst_n = 1'b0;
        drive(3'b111, 24'h030201, 1'b1);
        check("rst_w_acc", w_acc, 0);
        check("rst_avail", data_avail, 0);
        check("rst_size", size, 0);
        check("rst_full", full, 0);
        check("rst_afull", afull, 0);
        drive(3'b000, 24'h0, 1'b0);
        #8 rst_n = 1'b1;
        tick;
        check("post_rst_rdata", r_data, 8'hFF);

        // Bypass with sparse lanes and same-cycle pop.
        drive(3'b101, 24'h330011, 1'b1);
        check("byp_rdata", r_data, 8'h11);
        check("byp_w_acc", w_acc, 3'b101);
        check("byp_avail", data_avail, 1);
        tick;
        drive(3'b000, 24'h0, 1'b0);
        check("byp_size", size, 1);
        check("byp_head", r_data, 8'h33);

        // Fill to the almost-full level.
        drive(3'b111, 24'h030201, 1'b0);
        check("fill1_acc", w_acc, 3'b111);
        tick;
        drive(3'b011, 24'h000504, 1'b0);
        check("fill2_acc", w_acc, 3'b011);
        tick;
        drive(3'b000, 24'h0, 1'b0);
        check("six_size", size, 6);
        check("six_afull", afull, 1);
        check("six_full", full, 0);

        // Partial accept at the capacity boundary, wrapping the tail.
        drive(3'b111, 24'h0C0B0A, 1'b0);
        check("part_acc", w_acc, 3'b011);
        tick;
        drive(3'b000, 24'h0, 1'b0);
        check("full_size", size, 8);
        check("full_full", full, 1);
        check("full_afull", afull, 1);

        // Pop on full does not free space for a same-cycle write.
        drive(3'b001, 24'h0000EE, 1'b1);
        check("fullpop_acc", w_acc, 3'b000);
        check("fullpop_rdata", r_data, 8'h33);
        tick;
        drive(3'b000, 24'h0, 1'b0);
        check("fullpop_size", size, 7);
        check("fullpop_full", full, 0);

        // Drain in compacted order.
        for (int i = 0; i < 7; i++) begin
            drive(3'b000, 24'h0, 1'b1);
            check("drain_rdata", r_data, drain_exp[i]);
            tick;
        end
        drive(3'b000, 24'h0, 1'b0);
        check("drain_size", size, 0);
        check("drain_afull", afull, 0);

        // Pop on empty is ignored.
        drive(3'b000, 24'h0, 1'b1);
        check("under_avail", data_avail, 0);
        check("under_rdata", r_data, 8'hFF);
        tick;
        drive(3'b000, 24'h0, 1'b0);
        check("under_size", size, 0);

        // Random lane masks against a queue scoreboard, across pointer wrap.
        pushed = 0;
        for (int cyc = 0; cyc < 400 && (pushed < 20 || q.size() != 0); cyc++) begin
            m = (pushed < 20) ? NW'($urandom_range(0, 7)) : '0;
            d = (NW*W)'($urandom);
            r = (pushed >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            drive(m, d, r);
            msz  = q.size();
            free = D - msz;
            k    = 0;
            ea   = '0;
            for (int i = 0; i < NW; i++) begin
                if (m[i]) begin
                    if (k < free) ea[i] = 1'b1;
                    k++;
                end
            end
            eav = (msz != 0) || (m != 0);
            erd = 8'hFF;
            if (msz != 0) erd = q[0];
            else for (int i = NW - 1; i >= 0; i--) if (m[i]) erd = d[i*W +: W];
            check("rnd_acc", w_acc, ea);
            check("rnd_avail", data_avail, eav);
            check("rnd_rdata", r_data, erd);
            skip = 1'b0;
            if (r && eav) begin
                if (msz != 0) void'(q.pop_front());
                else skip = 1'b1;
            end
            for (int i = 0; i < NW; i++) begin
                if (ea[i]) begin
                    if (skip) skip = 1'b0;
                    else q.push_back(d[i*W +: W]);
                    pushed++;
                end
            end
            tick;
            check("rnd_size", size, q.size());
        end
        check("rnd_pushed", pushed >= 20, 1);
        check("rnd_empty", q.size(), 0);

        // Mid-cycle asynchronous reset with five entries held.
        drive(3'b111, 24'h232221, 1'b0);
        tick;
        drive(3'b011, 24'h002524, 1'b0);
        tick;
        drive(3'b000, 24'h0, 1'b0);
        check("pre_rst_size", size, 5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_size", size, 0);
        check("mid_rst_full", full, 0);
        check("mid_rst_rdata", r_data, 8'hFF);
        check("mid_rst_avail", data_avail, 0);
        #2 rst_n = 1'b1;
        tick;
        check("after_rst_size", size, 0);
        check("after_rst_avail", data_avail, 0);
        check("after_rst_rdata", r_data, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
